noc_mem_traffic_gen: RTL and testbench

// NoC2 request initiator / NoC3 response checker for memory-path testbenches; it is the requester-side

---
 rtl/noc_mem_traffic_gen_if.sv | 32 +++
 rtl/noc_mem_traffic_gen.sv | 210 +++++++++++++++++++++
 tb/tb_noc_mem_traffic_gen.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_mem_traffic_gen_if.sv
// NoC2 request / NoC3 response channel pair between the traffic generator and a memory model.
`ifndef NOC_MEM_TG_DEFS
`define NOC_MEM_TG_DEFS
`define NOC_DATA_WIDTH         64
`define MSG_DST_CHIPID         63:50
`define MSG_DST_X              49:42
`define MSG_DST_Y              41:34
`define MSG_LENGTH             29:22
`define MSG_TYPE               21:14
`define MSG_MSHRID             13:6
`define MSG_DATA_SIZE          42:40
`define MSG_ADDR               39:0
`define MSG_DATA_SIZE_64B      3'b111
`define MSG_TYPE_LOAD_MEM      8'd19
`define MSG_TYPE_STORE_MEM     8'd20
`define MSG_TYPE_LOAD_MEM_ACK  8'd24
`define MSG_TYPE_STORE_MEM_ACK 8'd25
`endif

interface noc_mem_traffic_gen_if #(parameter int DW = `NOC_DATA_WIDTH);
   logic          noc_valid_out;
   logic [DW-1:0] noc_data_out;
   logic          noc_ready_out;
   logic          noc_valid_in;
   logic [DW-1:0] noc_data_in;
   logic          noc_ready_in;

   modport master (output noc_valid_out, noc_data_out, noc_ready_in,
                   input  noc_ready_out, noc_valid_in, noc_data_in);
   modport slave  (input  noc_valid_out, noc_data_out, noc_ready_in,
                   output noc_ready_out, noc_valid_in, noc_data_in);
endinterface

// File: rtl/noc_mem_traffic_gen.sv
// Store/load-back memory path checker: writes a per-word pattern to each line over NoC2,
// reads it back over NoC3 and counts mismatches, one transaction outstanding at a time.
`ifndef NOC_MEM_TG_DEFS
`define NOC_MEM_TG_DEFS
`define NOC_DATA_WIDTH         64
`define MSG_DST_CHIPID         63:50
`define MSG_DST_X              49:42
`define MSG_DST_Y              41:34
`define MSG_LENGTH             29:22
`define MSG_TYPE               21:14
`define MSG_MSHRID             13:6
`define MSG_DATA_SIZE          42:40
`define MSG_ADDR               39:0
`define MSG_DATA_SIZE_64B      3'b111
`define MSG_TYPE_LOAD_MEM      8'd19
`define MSG_TYPE_STORE_MEM     8'd20
`define MSG_TYPE_LOAD_MEM_ACK  8'd24
`define MSG_TYPE_STORE_MEM_ACK 8'd25
`endif

module noc_mem_traffic_gen #(
   parameter logic [13:0] DST_CHIPID     = 14'd0,
   parameter logic [7:0]  DST_X          = 8'd0,
   parameter logic [7:0]  DST_Y          = 8'd0,
   parameter logic [31:0] SEED           = 32'hA5A5_5A5A,
   parameter int          TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [39:0]           base_addr,
   input  logic [15:0]           num_lines,
   noc_mem_traffic_gen_if.master noc,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [15:0]           err_count,
   output logic [15:0]           lines_done
);
   localparam int DW = `NOC_DATA_WIDTH;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ST_HDR  = 3'd1;
   localparam logic [2:0] ST_DATA = 3'd2;
   localparam logic [2:0] ST_ACK  = 3'd3;
   localparam logic [2:0] LD_HDR  = 3'd4;
   localparam logic [2:0] LD_RESP = 3'd5;
   localparam logic [2:0] NEXT    = 3'd6;
   localparam logic [2:0] FIN     = 3'd7;

   logic [2:0]    state;
   logic [3:0]    fcnt;
   logic [15:0]   line_idx;
   logic [15:0]   num_q;
   logic [33:0]   base_line;
   logic [TW-1:0] tmo;
   logic [39:0]   line_addr;
   logic [DW-1:0] hdr1, hdr2, rx_exp;
   logic [2:0]    rx_word;
   logic          tx_fire, rx_fire, rx_bad, tmo_hit;

   // Word k of a line lives at {line, k, 3'b0}; only the low 32 address bits feed the pattern.
   function automatic logic [DW-1:0] pattern(input logic [25:0] line_lo, input logic [2:0] k);
      logic [31:0] w;
      w = {line_lo, k, 3'b000};
      return {w ^ SEED, w};
   endfunction

   assign line_addr = {base_line + {18'd0, line_idx}, 6'b000};
   assign tx_fire   = noc.noc_valid_out & noc.noc_ready_out;
   assign rx_fire   = noc.noc_valid_in & noc.noc_ready_in;
   assign rx_word   = fcnt[2:0] - 3'd1;
   assign rx_exp    = pattern(line_addr[31:6], rx_word);
   assign tmo_hit   = (tmo == TW'(TIMEOUT_CYCLES - 1));

   assign noc.noc_valid_out = (state == ST_HDR) || (state == ST_DATA) || (state == LD_HDR);
   assign noc.noc_ready_in  = (state == ST_ACK) || (state == LD_RESP);
   assign busy              = (state != IDLE) && (state != FIN);

   always_comb begin
      hdr1                  = '0;
      hdr1[`MSG_DST_CHIPID] = DST_CHIPID;
      hdr1[`MSG_DST_X]      = DST_X;
      hdr1[`MSG_DST_Y]      = DST_Y;
      hdr1[`MSG_LENGTH]     = (state == LD_HDR) ? 8'd2 : 8'd10;
      hdr1[`MSG_TYPE]       = (state == LD_HDR) ? `MSG_TYPE_LOAD_MEM : `MSG_TYPE_STORE_MEM;
      hdr1[`MSG_MSHRID]     = line_idx[7:0];
      hdr2                  = '0;
      hdr2[`MSG_DATA_SIZE]  = `MSG_DATA_SIZE_64B;
      hdr2[`MSG_ADDR]       = line_addr;
   end

   // Output flit is a pure function of registered state, so it stays put under backpressure.
   always_comb begin
      noc.noc_data_out = '0;
      case (state)
         ST_HDR, LD_HDR: begin
            if (fcnt == 4'd0)      noc.noc_data_out = hdr1;
            else if (fcnt == 4'd1) noc.noc_data_out = hdr2;
         end
         ST_DATA: noc.noc_data_out = pattern(line_addr[31:6], fcnt[2:0]);
         default: ;
      endcase
   end

   always_comb begin
      rx_bad = 1'b0;
      if (state == ST_ACK)
         rx_bad = (noc.noc_data_in[`MSG_TYPE] != `MSG_TYPE_STORE_MEM_ACK) ||
                  (noc.noc_data_in[`MSG_LENGTH] != 8'd0) ||
                  (noc.noc_data_in[`MSG_MSHRID] != line_idx[7:0]);
      else if (fcnt == 4'd0)
         rx_bad = (noc.noc_data_in[`MSG_TYPE] != `MSG_TYPE_LOAD_MEM_ACK) ||
                  (noc.noc_data_in[`MSG_LENGTH] != 8'd8) ||
                  (noc.noc_data_in[`MSG_MSHRID] != line_idx[7:0]);
      else
         rx_bad = (noc.noc_data_in != rx_exp);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         fcnt       <= '0;
         line_idx   <= '0;
         num_q      <= '0;
         base_line  <= '0;
         tmo        <= '0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         lines_done <= '0;
      end else begin
         if (rx_fire && rx_bad && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;

         // Idle gap on the response channel; cleared on every accepted flit or outside wait states.
         if (rx_fire || !noc.noc_ready_in) tmo <= '0;
         else if (!tmo_hit)                tmo <= tmo + TW'(1);

         case (state)
            IDLE, FIN: begin
               if (start) begin
                  err_count  <= '0;
                  lines_done <= '0;
                  line_idx   <= '0;
                  fcnt       <= '0;
                  num_q      <= num_lines;
                  base_line  <= base_addr[39:6];
                  if (num_lines == 16'd0) begin
                     state <= FIN;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end else begin
                     state <= ST_HDR;
                     done  <= 1'b0;
                     pass  <= 1'b0;
                  end
               end else if (state == FIN) begin
                  state <= IDLE;
               end
            end
            ST_HDR, LD_HDR: if (tx_fire) begin
               if (fcnt == 4'd2) begin
                  fcnt  <= '0;
                  state <= (state == ST_HDR) ? ST_DATA : LD_RESP;
               end else begin
                  fcnt <= fcnt + 4'd1;
               end
            end
            ST_DATA: if (tx_fire) begin
               if (fcnt == 4'd7) begin
                  fcnt  <= '0;
                  state <= ST_ACK;
               end else begin
                  fcnt <= fcnt + 4'd1;
               end
            end
            ST_ACK, LD_RESP: begin
               if (rx_fire) begin
                  if (state == ST_ACK) begin
                     state <= LD_HDR;
                  end else if (fcnt == 4'd8) begin
                     fcnt  <= '0;
                     state <= NEXT;
                  end else begin
                     fcnt <= fcnt + 4'd1;
                  end
               end else if (tmo_hit) begin
                  state <= FIN;
                  done  <= 1'b1;
                  pass  <= 1'b0;
               end
            end
            NEXT: begin
               lines_done <= lines_done + 16'd1;
               if (line_idx + 16'd1 < num_q) begin
                  line_idx <= line_idx + 16'd1;
                  state    <= ST_HDR;
               end else begin
                  state <= FIN;
                  done  <= 1'b1;
                  pass  <= (err_count == 16'd0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_noc_mem_traffic_gen.sv
// Bench: NoC memory model responder with random stalls/corruption, expected request-flit queue,
// and end-of-run result checks.
module tb_noc_mem_traffic_gen;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [39:0] base_addr = '0;
   logic [15:0] num_lines = '0;
   logic        busy, done, pass;
   logic [15:0] err_count, lines_done;

   int n_chk = 0, n_err = 0, cyc = 0;

   noc_mem_traffic_gen_if nif();

   noc_mem_traffic_gen #(
      .DST_CHIPID(14'd5), .DST_X(8'd3), .DST_Y(8'd2),
      .SEED(32'hA5A5_5A5A), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_lines(num_lines),
      .noc(nif), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .lines_done(lines_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   localparam logic [63:0] CHIP = 64'd5, XX = 64'd3, YY = 64'd2;
   localparam logic [31:0] SEED_K = 32'hA5A5_5A5A;

   logic [63:0] exp_q[$], cap[$], req_buf[$], rsp_q[$];
   logic [63:0] mem [logic [39:0]];
   bit          corrupt_map [int];
   int          ack_bad_line = -1;
   bit          drop_ack = 0, stall = 0, rx_took = 0, hold_pending = 0;
   logic [63:0] hold_data;
   int          last_tx_edge = 0, done_edge = 0, valid_cycles = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [39:0] line_a(input logic [39:0] base, input int i);
      logic [33:0] l;
      l = base[39:6] + 34'(i);
      return {l, 6'b0};
   endfunction

   function automatic logic [63:0] pat(input logic [39:0] w);
      logic [31:0] lo;
      lo = w[31:0];
      return {lo ^ SEED_K, lo};
   endfunction

   function automatic logic [63:0] hdr(input logic [7:0] typ, input logic [7:0] len, input logic [7:0] m);
      return (CHIP << 50) | (XX << 42) | (YY << 34) | (64'(len) << 22) | (64'(typ) << 14) | (64'(m) << 6);
   endfunction

   function automatic logic [63:0] hdr_addr(input logic [39:0] a);
      return (64'd7 << 40) | 64'(a);
   endfunction

   task automatic build_exp(input logic [39:0] base, input int n, input bit store_only);
      logic [39:0] a;
      for (int i = 0; i < n; i++) begin
         a = line_a(base, i);
         exp_q.push_back(hdr(8'd20, 8'd10, 8'(i)));
         exp_q.push_back(hdr_addr(a));
         exp_q.push_back(64'd0);
         for (int k = 0; k < 8; k++) exp_q.push_back(pat(a + 40'(8 * k)));
         if (store_only) return;
         exp_q.push_back(hdr(8'd19, 8'd2, 8'(i)));
         exp_q.push_back(hdr_addr(a));
         exp_q.push_back(64'd0);
      end
   endtask

   // Memory model: act on a request message once all length+1 flits have arrived.
   task automatic serve();
      logic [63:0] h, f1, d;
      logic [39:0] a;
      logic [7:0]  m, len, typ;
      h   = req_buf[0];
      len = h[29:22];
      if (req_buf.size() != int'(len) + 1) return;
      typ = h[21:14];
      m   = h[13:6];
      f1  = req_buf[1];
      a   = f1[39:0];
      if (typ == 8'd20) begin
         for (int k = 0; k < 8; k++) mem[a + 40'(8 * k)] = req_buf[3 + k];
         if (!drop_ack)
            rsp_q.push_back(hdr((int'(m) == ack_bad_line) ? 8'd24 : 8'd25, 8'd0, m));
      end else begin
         rsp_q.push_back(hdr(8'd24, 8'd8, m));
         for (int k = 0; k < 8; k++) begin
            d = mem.exists(a + 40'(8 * k)) ? mem[a + 40'(8 * k)] : 64'd0;
            if (corrupt_map.exists(int'(m) * 8 + k)) d = d ^ 64'hFF00;
            rsp_q.push_back(d);
         end
      end
      req_buf.delete();
   endtask

   // Compare/monitor on the falling edge, drive responder inputs just after the rising edge.
   initial begin
      nif.noc_ready_out = 1'b0;
      nif.noc_valid_in  = 1'b0;
      nif.noc_data_in   = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            req_buf.delete();
            rsp_q.delete();
            rx_took      = 0;
            hold_pending = 0;
         end else begin
            if (hold_pending) begin
               chk("hold_valid", 64'(nif.noc_valid_out), 64'd1);
               chk("hold_data", nif.noc_data_out, hold_data);
            end
            if (nif.noc_valid_out) begin
               valid_cycles++;
               chk("valid_only_when_busy", 64'(busy), 64'd1);
            end
            if (nif.noc_valid_out && nif.noc_ready_out) begin
               cap.push_back(nif.noc_data_out);
               last_tx_edge = cyc + 1;
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_err++;
                  $display("FAIL unexpected_flit: got %h expected none", nif.noc_data_out);
               end else begin
                  chk("tx_flit", nif.noc_data_out, exp_q.pop_front());
               end
               req_buf.push_back(nif.noc_data_out);
               serve();
            end
            hold_pending = nif.noc_valid_out && !nif.noc_ready_out;
            hold_data    = nif.noc_data_out;
            if (nif.noc_valid_in && nif.noc_ready_in) begin
               rx_took = 1;
               void'(rsp_q.pop_front());
            end
         end
         @(posedge clk);
         #1;
         if (!rst_n) begin
            nif.noc_valid_in  = 1'b0;
            nif.noc_ready_out = 1'b0;
            rx_took           = 0;
         end else begin
            nif.noc_ready_out = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rx_took) begin
               nif.noc_valid_in = 1'b0;
               rx_took = 0;
            end
            if (!nif.noc_valid_in && rsp_q.size() > 0 && (!stall || $urandom_range(0, 2) != 0)) begin
               nif.noc_valid_in = 1'b1;
               nif.noc_data_in  = rsp_q[0];
            end
         end
      end
   end

   task automatic pulse_start(input logic [39:0] base, input int n);
      @(posedge clk);
      #1;
      base_addr = base;
      num_lines = 16'(n);
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run(input logic [39:0] base, input int n, input bit store_only, input int exp_errs,
                      input bit exp_pass, input int exp_lines, output int waited);
      exp_q.delete();
      build_exp(base, n, store_only);
      cap.delete();
      mem.delete();
      valid_cycles = 0;
      pulse_start(base, n);
      waited = 0;
      while (1) begin
         @(negedge clk);
         waited++;
         if (done) begin
            done_edge = cyc;
            break;
         end
         if (waited >= 8000) break;
      end
      chk("done", 64'(done), 64'd1);
      chk("pass", 64'(pass), 64'(exp_pass));
      chk("err_count", 64'(err_count), 64'(exp_errs));
      chk("lines_done", 64'(lines_done), 64'(exp_lines));
      chk("busy_at_done", 64'(busy), 64'd0);
      chk("tx_remaining", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int w, n, k, nerr;
      logic [63:0] r;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_pass", 64'(pass), 64'd0);
      chk("rst_err", 64'(err_count), 64'd0);
      chk("rst_lines", 64'(lines_done), 64'd0);
      chk("rst_valid_out", 64'(nif.noc_valid_out), 64'd0);
      chk("rst_ready_in", 64'(nif.noc_ready_in), 64'd0);
      rst_n = 1'b1;

      // single line, ideal memory; literal flit values pin the model
      run(40'h0, 1, 0, 0, 1, 1, w);
      chk("t1_flits", 64'(cap.size()), 64'd14);
      chk("t1_st_hdr1", cap[0], 64'h0014_0C08_0285_0000);
      chk("t1_st_hdr2", cap[1], 64'h0000_0700_0000_0000);
      chk("t1_word1", cap[4], 64'hA5A5_5A52_0000_0008);
      chk("t1_ld_hdr1", cap[11], 64'h0014_0C08_0084_C000);

      // four lines with random stalls on both channels
      stall = 1;
      run(40'h1040, 4, 0, 0, 1, 4, w);
      chk("t2_first_addr", cap[1], 64'h0000_0700_0000_1040);
      chk("t2_last_addr", cap[43], 64'h0000_0700_0000_1100);
      stall = 0;

      // one corrupted word on line 2
      corrupt_map[2 * 8 + 3] = 1;
      run(40'h3000, 3, 0, 1, 0, 3, w);
      corrupt_map.delete();

      // store ack dropped -> timeout 64 cycles after the last data flit
      drop_ack = 1;
      run(40'h4000, 2, 1, 0, 0, 0, w);
      chk("t4_timeout_gap", 64'(done_edge - last_tx_edge), 64'd64);
      drop_ack = 0;

      // zero lines
      run(40'h5000, 0, 0, 0, 1, 0, w);
      chk("t5_done_latency", 64'(w), 64'd1);
      chk("t5_no_valid", 64'(valid_cycles), 64'd0);

      // reset while data flit 4 of the store is on the bus
      exp_q.delete();
      build_exp(40'h6000, 1, 0);
      cap.delete();
      pulse_start(40'h6000, 1);
      w = 0;
      while (cap.size() < 7 && w < 1000) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("t6_pre_reset_flits", 64'(cap.size()), 64'd7);
      rst_n = 1'b0;
      #1;
      chk("t6_valid_out", 64'(nif.noc_valid_out), 64'd0);
      chk("t6_ready_in", 64'(nif.noc_ready_in), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_done", 64'(done), 64'd0);
      chk("t6_err", 64'(err_count), 64'd0);
      chk("t6_lines", 64'(lines_done), 64'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      run(40'h6000, 1, 0, 0, 1, 1, w);
      chk("t6_clean_flits", 64'(cap.size()), 64'd14);
      chk("t6_first_flit", cap[0], 64'h0014_0C08_0285_0000);

      // randomized runs: random base, length, data corruptions and bad store acks
      stall = 1;
      for (int it = 0; it < 4; it++) begin
         r = {$urandom, $urandom};
         n = $urandom_range(1, 5);
         k = $urandom_range(0, 2);
         while (corrupt_map.size() < k) corrupt_map[$urandom_range(0, n * 8 - 1)] = 1;
         nerr = k;
         ack_bad_line = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, n - 1)) : -1;
         if (ack_bad_line >= 0) nerr++;
         run(r[39:0], n, 0, nerr, nerr == 0, n, w);
         corrupt_map.delete();
         ack_bad_line = -1;
      end
      stall = 0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
